// File: rtl/mvu_apb_cfg.sv
// mvu_apb_cfg: APB slave register file for the MVU.
// It holds the job configuration, generates the start pulse, and tracks done/irq status.
module mvu_apb_cfg #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic                  mvu_busy,
    input  logic                  mvu_done,
    output logic                  cfg_start,
    output logic [5:0]            cfg_wprec,
    output logic [5:0]            cfg_iprec,
    output logic [5:0]            cfg_oprec,
    output logic [5:0]            cfg_quant_msb,
    output logic [15:0]           cfg_wbase,
    output logic [15:0]           cfg_ibase,
    output logic [15:0]           cfg_obase,
    output logic [15:0]           cfg_count,
    output logic [15:0]           cfg_scaler,
    output logic signed [31:0]    cfg_bias,
    output logic                  cfg_relu_en,
    output logic                  irq
);

    typedef enum logic [3:0] {
        REG_CTRL   = 4'h0,
        REG_STATUS = 4'h1,
        REG_PREC   = 4'h2,
        REG_QMSB   = 4'h3,
        REG_WBASE  = 4'h4,
        REG_IBASE  = 4'h5,
        REG_OBASE  = 4'h6,
        REG_COUNT  = 4'h7,
        REG_SCALER = 4'h8,
        REG_BIAS   = 4'h9
    } reg_e;

    reg_e        sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        access;
    logic        wr_acc;
    logic        rd_acc;
    logic        addr_bad;
    logic        status_bad;
    logic        start_busy;
    logic        wr_ok;
    logic        start_req;
    logic        w1c_done;
    logic        irq_en;
    logic        irq_en_nxt;
    logic        done;
    logic        done_nxt;
    logic        addr_lsb_unused;

    assign sel             = reg_e'(paddr[5:2]);
    assign wdata           = pwdata[31:0];
    assign addr_lsb_unused = ^paddr[1:0];
    assign pready          = 1'b1;

    // Access decode, error classification and next values of the status bits.
    always_comb begin
        access     = psel & penable;
        wr_acc     = access & pwrite;
        rd_acc     = access & ~pwrite;
        addr_bad   = (paddr > ADDR_WIDTH'(63)) || (paddr[5:2] > 4'd9);
        status_bad = wr_acc & (sel == REG_STATUS) & ~wdata[1];
        start_busy = wr_acc & (sel == REG_CTRL) & wdata[0] & mvu_busy;
        // A START rejected for busy still commits the other CTRL bits.
        wr_ok      = wr_acc & ~addr_bad & ~status_bad;
        start_req  = wr_ok & (sel == REG_CTRL) & wdata[0] & ~mvu_busy;
        w1c_done   = wr_ok & (sel == REG_STATUS);
        irq_en_nxt = (wr_ok && sel == REG_CTRL) ? wdata[1] : irq_en;
        // Set beats clear when mvu_done and W1C land together.
        done_nxt   = mvu_done | (done & ~w1c_done);
        pslverr    = ~rst & access & (addr_bad | status_bad | start_busy);
    end

    // Read mux: drive data only during a valid read access phase.
    always_comb begin
        rdata = '0;
        if (rd_acc && !addr_bad && !rst) begin
            case (sel)
                REG_CTRL:   rdata = {29'd0, cfg_relu_en, irq_en, 1'b0};
                REG_STATUS: rdata = {30'd0, done, mvu_busy};
                REG_PREC:   rdata = {14'd0, cfg_oprec, cfg_iprec, cfg_wprec};
                REG_QMSB:   rdata = {26'd0, cfg_quant_msb};
                REG_WBASE:  rdata = {16'd0, cfg_wbase};
                REG_IBASE:  rdata = {16'd0, cfg_ibase};
                REG_OBASE:  rdata = {16'd0, cfg_obase};
                REG_COUNT:  rdata = {16'd0, cfg_count};
                REG_SCALER: rdata = {16'd0, cfg_scaler};
                REG_BIAS:   rdata = cfg_bias;
                default:    rdata = '0;
            endcase
        end
        prdata = DATA_WIDTH'(rdata);
    end

    // Register state: config fields, start pulse, done flag and irq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_start     <= 1'b0;
            cfg_wprec     <= '0;
            cfg_iprec     <= '0;
            cfg_oprec     <= '0;
            cfg_quant_msb <= '0;
            cfg_wbase     <= '0;
            cfg_ibase     <= '0;
            cfg_obase     <= '0;
            cfg_count     <= '0;
            cfg_scaler    <= '0;
            cfg_bias      <= '0;
            cfg_relu_en   <= 1'b0;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            irq           <= 1'b0;
        end else begin
            cfg_start <= start_req;
            irq_en    <= irq_en_nxt;
            done      <= done_nxt;
            irq       <= done_nxt & irq_en_nxt;
            if (wr_ok) begin
                case (sel)
                    REG_CTRL:   cfg_relu_en <= wdata[2];
                    REG_PREC: begin
                        cfg_wprec <= wdata[5:0];
                        cfg_iprec <= wdata[11:6];
                        cfg_oprec <= wdata[17:12];
                    end
                    REG_QMSB:   cfg_quant_msb <= wdata[5:0];
                    REG_WBASE:  cfg_wbase     <= wdata[15:0];
                    REG_IBASE:  cfg_ibase     <= wdata[15:0];
                    REG_OBASE:  cfg_obase     <= wdata[15:0];
                    REG_COUNT:  cfg_count     <= wdata[15:0];
                    REG_SCALER: cfg_scaler    <= wdata[15:0];
                    REG_BIAS:   cfg_bias      <= $signed(wdata);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mvu_apb_cfg.sv
// tb_mvu_apb_cfg: randomized APB traffic against a register-map model, plus directed literal checks.
`timescale 1ns/1ps
module tb_mvu_apb_cfg;

    logic               clk = 1'b0;
    logic               rst;
    logic               psel, penable, pwrite;
    logic [11:0]        paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready, pslverr;
    logic               mvu_busy, mvu_done;
    logic               cfg_start;
    logic [5:0]         cfg_wprec, cfg_iprec, cfg_oprec, cfg_quant_msb;
    logic [15:0]        cfg_wbase, cfg_ibase, cfg_obase, cfg_count, cfg_scaler;
    logic signed [31:0] cfg_bias;
    logic               cfg_relu_en, irq;

    int total = 0;
    int bad   = 0;
    bit rnd_env = 1'b0;
    bit chk_on  = 1'b0;

    // Model: stored register words by index, plus control/status bits.
    logic [31:0] m_reg [10];
    bit m_irq_en, m_relu, m_done, m_start, m_irq;

    always #5 clk = ~clk;

    mvu_apb_cfg #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .mvu_busy(mvu_busy), .mvu_done(mvu_done), .cfg_start(cfg_start),
        .cfg_wprec(cfg_wprec), .cfg_iprec(cfg_iprec), .cfg_oprec(cfg_oprec),
        .cfg_quant_msb(cfg_quant_msb), .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase),
        .cfg_obase(cfg_obase), .cfg_count(cfg_count), .cfg_scaler(cfg_scaler),
        .cfg_bias(cfg_bias), .cfg_relu_en(cfg_relu_en), .irq(irq)
    );

    function automatic logic [31:0] fmask(input int idx);
        case (idx)
            2:       return 32'h0003_FFFF;
            3:       return 32'h0000_003F;
            9:       return 32'hFFFF_FFFF;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

    function automatic bit adr_bad();
        return (paddr > 12'h03F) || (paddr[5:2] > 4'd9);
    endfunction

    function automatic void model_clear();
        foreach (m_reg[i]) m_reg[i] = 32'h0;
        m_irq_en = 0; m_relu = 0; m_done = 0; m_start = 0; m_irq = 0;
    endfunction

    function automatic void model_step();
        int idx;
        bit wr;
        bit clr;
        idx = int'(paddr[5:2]);
        wr  = psel && penable && pwrite && !adr_bad();
        clr = 0;
        m_start = 0;
        if (wr) begin
            if (idx == 0) begin
                m_irq_en = pwdata[1];
                m_relu   = pwdata[2];
                m_start  = pwdata[0] && !mvu_busy;
            end else if (idx == 1) begin
                clr = pwdata[1];
            end else begin
                m_reg[idx] = pwdata & fmask(idx);
            end
        end
        m_done = mvu_done || (m_done && !clr);
        m_irq  = m_done && m_irq_en;
    endfunction

    function automatic logic [31:0] exp_rdata();
        int idx;
        idx = int'(paddr[5:2]);
        if (rst || !(psel && penable && !pwrite) || adr_bad()) return 32'h0;
        if (idx == 0) return {29'd0, m_relu, m_irq_en, 1'b0};
        if (idx == 1) return {30'd0, m_done, mvu_busy};
        return m_reg[idx];
    endfunction

    function automatic logic exp_slverr();
        if (rst || !(psel && penable)) return 1'b0;
        if (adr_bad()) return 1'b1;
        if (pwrite && paddr[5:2] == 4'd1 && !pwdata[1]) return 1'b1;
        if (pwrite && paddr[5:2] == 4'd0 && pwdata[0] && mvu_busy) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cfg_start", cfg_start, m_start);
            chk("irq", irq, m_irq);
            chk("relu_en", cfg_relu_en, m_relu);
            chk("wprec", cfg_wprec, m_reg[2][5:0]);
            chk("iprec", cfg_iprec, m_reg[2][11:6]);
            chk("oprec", cfg_oprec, m_reg[2][17:12]);
            chk("qmsb", cfg_quant_msb, m_reg[3]);
            chk("wbase", cfg_wbase, m_reg[4]);
            chk("ibase", cfg_ibase, m_reg[5]);
            chk("obase", cfg_obase, m_reg[6]);
            chk("count", cfg_count, m_reg[7]);
            chk("scaler", cfg_scaler, m_reg[8]);
            chk("bias", cfg_bias, m_reg[9]);
            chk("prdata", prdata, exp_rdata());
            chk("pslverr", pslverr, exp_slverr());
            chk("pready", pready, 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_clear(); else model_step();
        #1;
        if (rnd_env) begin
            mvu_busy = ($urandom_range(0, 3) == 0);
            mvu_done = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        tick();
        penable = 1;
        #4 err = pslverr;
        tick();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] rd, output logic err);
        psel = 1; penable = 0; pwrite = 0; paddr = a; pwdata = 32'h0;
        tick();
        penable = 1;
        #4 begin rd = prdata; err = pslverr; end
        tick();
        psel = 0; penable = 0;
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [11:0] a;
        logic [31:0] d;

        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        mvu_busy = 0; mvu_done = 0;
        model_clear();
        chk_on = 1;
        tick(); tick();
        #4;
        chk("rst_start", cfg_start, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_bias", cfg_bias, 32'h0);
        chk("rst_pready", pready, 1'b1);
        tick();
        rst = 0;
        tick();

        // Precision fields
        apb_wr(12'h008, 32'h0000_2082, e);
        chk("prec_wr_err", e, 1'b0);
        apb_rd(12'h008, r, e);
        chk("prec_rd", r, 32'h0000_2082);
        chk("wprec_lit", cfg_wprec, 6'd2);
        chk("iprec_lit", cfg_iprec, 6'd2);
        chk("oprec_lit", cfg_oprec, 6'd2);

        // Signed bias
        apb_wr(12'h024, 32'hFFFF_FFF6, e);
        chk("bias_lit", (cfg_bias == -10), 1'b1);
        apb_rd(12'h024, r, e);
        chk("bias_rd", r, 32'hFFFF_FFF6);

        // Start pulse
        apb_wr(12'h000, 32'h3, e);
        #4 chk("start_hi", cfg_start, 1'b1);
        tick();
        #4 chk("start_lo", cfg_start, 1'b0);
        apb_rd(12'h000, r, e);
        chk("ctrl_rd", r, 32'h2);

        // Done and irq
        mvu_done = 1;
        tick();
        mvu_done = 0;
        #4 chk("irq_set", irq, 1'b1);
        apb_rd(12'h004, r, e);
        chk("status_done", r, 32'h2);
        apb_wr(12'h004, 32'h2, e);
        #4 chk("irq_clr", irq, 1'b0);

        // Error responses
        apb_rd(12'h028, r, e);
        chk("bad_rd_err", e, 1'b1);
        chk("bad_rd_data", r, 32'h0);
        mvu_done = 1;
        tick();
        mvu_done = 0;
        apb_wr(12'h004, 32'h0, e);
        chk("status0_err", e, 1'b1);
        apb_rd(12'h004, r, e);
        chk("status0_keep", r, 32'h2);
        apb_rd(12'h044, r, e);
        chk("hi_addr_err", e, 1'b1);

        // START while busy: rejected, other CTRL bits still update
        mvu_busy = 1;
        apb_wr(12'h000, 32'h5, e);
        chk("busy_start_err", e, 1'b1);
        #4 chk("busy_no_start", cfg_start, 1'b0);
        chk("busy_relu", cfg_relu_en, 1'b1);
        mvu_busy = 0;
        tick();

        // Randomized traffic
        rnd_env = 1;
        for (int n = 0; n < 400; n++) begin
            a = 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | 12'($urandom_range(1, 63) << 6);
            d = $urandom();
            if ($urandom_range(0, 1) == 0) apb_wr(a, d, e);
            else apb_rd(a, r, e);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_env = 0;
        mvu_busy = 0;
        mvu_done = 0;
        tick();

        // Program everything, then reset in the middle of a write
        apb_wr(12'h000, 32'h6, e);
        apb_wr(12'h008, 32'h3FFFF, e);
        apb_wr(12'h00C, 32'h3F, e);
        apb_wr(12'h010, 32'hFFFF, e);
        apb_wr(12'h014, 32'h1234, e);
        apb_wr(12'h018, 32'h5678, e);
        apb_wr(12'h01C, 32'h9ABC, e);
        apb_wr(12'h020, 32'hDEF0, e);
        apb_wr(12'h024, 32'h1234_5678, e);
        mvu_done = 1;
        tick();
        mvu_done = 0;
        psel = 1; penable = 0; pwrite = 1; paddr = 12'h010; pwdata = 32'hAAAA;
        tick();
        penable = 1;
        #2 rst = 1;
        model_clear();
        #2;
        chk("mid_rst_wbase", cfg_wbase, 16'h0);
        chk("mid_rst_bias", cfg_bias, 32'h0);
        chk("mid_rst_irq", irq, 1'b0);
        chk("mid_rst_relu", cfg_relu_en, 1'b0);
        chk("mid_rst_prec", {cfg_oprec, cfg_iprec, cfg_wprec}, 18'h0);
        chk("mid_rst_slverr", pslverr, 1'b0);
        chk("mid_rst_pready", pready, 1'b1);
        tick();
        psel = 0; penable = 0; pwrite = 0;
        rst = 0;
        tick();
        for (int k = 0; k < 10; k++) begin
            apb_rd(12'(k * 4), r, e);
            chk("post_rst_rd", r, 32'h0);
        end

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
